// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the RV32I load/store port. Accepts one
// word-granular request at a time, waits a fixed LATENCY, then commits a
// byte-enabled store or captures load data and holds a response until the
// initiator takes it.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The request channel is ready only in IDLE.
// The response channel holds rsp_valid and its payload stable until the edge
// where rsp_ready is 1. Exactly one request is outstanding at any time.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (legal word index 0..DEPTH_WORDS-1)
//   LATENCY     : cycles from request accept to rsp_valid, 1..15
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (array contents persist)
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle (registered)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address (must be word aligned and in range)
//   req_wdata  in   store data
//   req_wstrb  in   store byte enables, bit i -> lane [8i+7:8i]
//   rsp_valid  out  response present (registered)
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  load data; 0 for stores, errors and outside RESP
//   rsp_err    out  misaligned or out-of-range request
//   dbg_state  out  FSM state: 0 = IDLE, 1 = WAIT, 2 = RESP
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request captured at accept.
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic [31:0] mem [DEPTH_WORDS];

  // Commit-side view of the request. With LATENCY=1 the commit happens on the
  // accept edge itself, so the live request inputs are used in IDLE.
  logic          c_write;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_wstrb;
  logic          c_err;
  logic [AW-1:0] c_idx;
  logic          commit;

  always_comb begin
    c_write = lat_write;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_wstrb = lat_wstrb;
    if (state == S_IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wstrb = req_wstrb;
    end
    // Full 30-bit word index against the depth: a high address must never
    // alias onto a low word.
    c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= DEPTH_W);
    c_idx = c_addr[AW+1:2];

    commit = 1'b0;
    if ((state == S_IDLE) && req_valid && (LATENCY == 1)) begin
      commit = 1'b1;
    end
    // The counter is loaded with LATENCY-1 at accept; the commit is the edge
    // that takes it from 1 to 0, which places rsp_valid LATENCY cycles after
    // the accept edge.
    if ((state == S_WAIT) && (cnt == 4'd1)) begin
      commit = 1'b1;
    end
  end

  // Array write port. Reset forces the FSM to IDLE asynchronously, so a store
  // still in WAIT can never reach this port once rst_n drops.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_wstrb[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_wstrb <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            cnt       <= LAT_LOAD;
            req_ready <= 1'b0;
            if (commit) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= c_err;
              rsp_rdata <= (c_err || c_write) ? 32'd0 : mem[c_idx];
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (commit) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= c_err;
            rsp_rdata <= (c_err || c_write) ? 32'd0 : mem[c_idx];
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Four responders with LATENCY 1, 2, 4 and 5 run side by side from one clock
// and reset; instance 2 (LATENCY=4) carries the bulk of the directed and
// random traffic. A per-instance word-array model predicts every response,
// and expectations flow through an expected queue popped at each response.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int N     = 4;
  localparam int DEPTH = 64;
  localparam int MAIN  = 2;
  localparam logic [N-1:0][3:0] LATS = {4'd5, 4'd4, 4'd2, 4'd1};

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_write;
  logic [N-1:0]       rsp_ready;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0][31:0] req_wdata;
  logic [N-1:0][3:0]  req_wstrb;
  wire  [N-1:0]       req_ready;
  wire  [N-1:0]       rsp_valid;
  wire  [N-1:0]       rsp_err;
  wire  [N-1:0][31:0] rsp_rdata;
  wire  [N-1:0][1:0]  dbg_state;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (int'(LATS[g]))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wstrb (req_wstrb[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // ---------------------------------------------------------------- scoreboard
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem   [N][DEPTH];
  bit          model_known [N][DEPTH];
  logic [32:0] exp_q[$];        // {err, rdata}
  bit          exp_known_q[$];  // rdata is predictable

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: an access is an error if misaligned or its word index is past
  // the end of the array; stores merge enabled bytes, loads return the word.
  task automatic model_push(input int i, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    int w;
    if ((a % 4) != 0 || (a / 4) >= DEPTH) begin
      exp_q.push_back({1'b1, 32'h0});
      exp_known_q.push_back(1'b1);
    end else begin
      w = int'(a / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[i][w][8*b +: 8] = d[8*b +: 8];
        if (s == 4'hf) model_known[i][w] = 1'b1;
        exp_q.push_back({1'b0, 32'h0});
        exp_known_q.push_back(1'b1);
      end else begin
        exp_q.push_back({1'b0, model_mem[i][w]});
        exp_known_q.push_back(model_known[i][w]);
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Entered and left at a falling edge; the request is accepted on the rising
  // edge in between, then the request pins are scrambled with valid low.
  task automatic send(input int i, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    check($sformatf("req_ready_pre%0d", i), 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wstrb[i] = s;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    req_write[i] = ~wr;
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_wstrb[i] = 4'($urandom_range(15));
  endtask

  // n counts falling edges after the accept edge; bounded.
  task automatic wait_rsp(input int i, output int n);
    n = 1;
    while (!rsp_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_rsp(input int i);
    logic [32:0] e;
    bit          k;
    e = exp_q.pop_front();
    k = exp_known_q.pop_front();
    check($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(e[32]));
    if (k) check($sformatf("rsp_rdata%0d", i), rsp_rdata[i], e[31:0]);
  endtask

  task automatic transact(input int i, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n;
    model_push(i, wr, a, d, s);
    send(i, wr, a, d, s);
    wait_rsp(i, n);
    check($sformatf("latency%0d", i), 32'(n), 32'(LATS[i]));
    check_rsp(i);
    @(negedge clk);
    check($sformatf("rsp_one_cycle%0d", i), 32'(rsp_valid[i]), 32'd0);
    check($sformatf("req_ready_post%0d", i), 32'(req_ready[i]), 32'd1);
    check($sformatf("rdata_idle%0d", i), rsp_rdata[i], 32'd0);
  endtask

  task automatic check_reset_outputs(input int i);
    check($sformatf("rst_req_ready%0d", i), 32'(req_ready[i]), 32'd1);
    check($sformatf("rst_rsp_valid%0d", i), 32'(rsp_valid[i]), 32'd0);
    check($sformatf("rst_rsp_err%0d", i), 32'(rsp_err[i]), 32'd0);
    check($sformatf("rst_rsp_rdata%0d", i), rsp_rdata[i], 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          n;
    logic [31:0] a;
    logic [31:0] v;

    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = '1;

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_reset_outputs(i);
      check($sformatf("rst_state%0d", i), 32'(dbg_state[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Store word then load, on every latency.
    for (int i = 0; i < N; i++) begin
      transact(i, 1'b1, 32'd16, 32'hABCDEF11, 4'hf);
      transact(i, 1'b0, 32'd16, 32'h0, 4'h0);
    end

    // Fill the main array so every later load is predictable.
    for (int w = 0; w < DEPTH; w++)
      transact(MAIN, 1'b1, 32'(w * 4), $urandom, 4'hf);

    // Byte strobes, including an empty strobe.
    transact(MAIN, 1'b1, 32'd12, 32'hFFFFFFFF, 4'hf);
    transact(MAIN, 1'b1, 32'd12, 32'h12345678, 4'b0101);
    transact(MAIN, 1'b0, 32'd12, 32'h0, 4'h0);
    transact(MAIN, 1'b1, 32'd12, 32'h00000000, 4'b0000);
    transact(MAIN, 1'b0, 32'd12, 32'h0, 4'h0);

    // Errors: misaligned, first word past the end, far out of range.
    transact(MAIN, 1'b0, 32'h6, 32'h0, 4'h0);
    transact(MAIN, 1'b1, 32'd256, 32'hDEADBEEF, 4'hf);
    transact(MAIN, 1'b1, 32'h4000_0000, 32'hCAFEF00D, 4'hf);
    transact(MAIN, 1'b1, 32'hFFFF_FFFC, 32'h0BADC0DE, 4'hf);
    transact(MAIN, 1'b1, 32'h0000_0102, 32'h11111111, 4'hf);

    // Backpressure: hold RESP for 7 cycles while a new store to the same word
    // is offered.
    rsp_ready[MAIN] = 1'b0;
    model_push(MAIN, 1'b0, 32'd20, 32'h0, 4'h0);
    send(MAIN, 1'b0, 32'd20, 32'h0, 4'h0);
    wait_rsp(MAIN, n);
    check("bp_latency", 32'(n), 32'(LATS[MAIN]));
    check_rsp(MAIN);
    for (int k = 0; k < 7; k++) begin
      req_valid[MAIN] = 1'b1;
      req_write[MAIN] = 1'b1;
      req_addr[MAIN]  = 32'd20;
      req_wdata[MAIN] = $urandom;
      req_wstrb[MAIN] = 4'hf;
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid[MAIN]), 32'd1);
      check("bp_req_ready", 32'(req_ready[MAIN]), 32'd0);
      check("bp_rdata", rsp_rdata[MAIN], model_mem[MAIN][5]);
    end
    req_valid[MAIN] = 1'b0;
    rsp_ready[MAIN] = 1'b1;
    @(negedge clk);
    check("bp_done_valid", 32'(rsp_valid[MAIN]), 32'd0);
    check("bp_done_ready", 32'(req_ready[MAIN]), 32'd1);
    transact(MAIN, 1'b0, 32'd20, 32'h0, 4'h0);

    // Reset while the store is in WAIT: store is discarded.
    transact(MAIN, 1'b1, 32'd8, 32'h600DF00D, 4'hf);
    send(MAIN, 1'b1, 32'd8, 32'h5555AAAA, 4'hf);
    check("wait_no_valid", 32'(rsp_valid[MAIN]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(MAIN);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    transact(MAIN, 1'b0, 32'd8, 32'h0, 4'h0);

    // Reset while in RESP: the committed store remains.
    rsp_ready[MAIN] = 1'b0;
    v = $urandom;
    model_push(MAIN, 1'b1, 32'd8, v, 4'hf);
    send(MAIN, 1'b1, 32'd8, v, 4'hf);
    wait_rsp(MAIN, n);
    check("resp_rst_latency", 32'(n), 32'(LATS[MAIN]));
    check_rsp(MAIN);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(MAIN);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready[MAIN] = 1'b1;
    @(negedge clk);
    transact(MAIN, 1'b0, 32'd8, 32'h0, 4'h0);

    // Random traffic, mostly legal.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(9))
        0:       a = $urandom;
        1:       a = 32'(4 * $urandom_range(63) + $urandom_range(3, 1));
        2:       a = 32'(4 * $urandom_range(70, 64));
        default: a = 32'(4 * $urandom_range(63));
      endcase
      transact(MAIN, 1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)));
    end

    // Whole-array read-back against the model.
    for (int w = 0; w < DEPTH; w++)
      transact(MAIN, 1'b0, 32'(w * 4), 32'h0, 4'h0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core's load/store port. It accepts one word-granular request at a time over a valid/ready handshake. It applies a fixed, parameterised access latency, commits byte-enabled writes or captures read data, and returns a response that the initiator must accept. It replaces the zero-latency data memory when the core's memory stage is exercised with wait states.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words; legal word indices are 0..DEPTH_WORDS-1.
- LATENCY, 2: cycles from request accept to first rsp_valid; legal range 1..15.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  initiator has a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte enables; bit i enables byte lane [8i+7:8i]; ignored on loads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned or out of range.

## Operation
- FSM states:
  - IDLE: req_ready=1. When req_valid=1, latch write, addr, wdata and wstrb, load the counter with LATENCY-1, then go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. On the edge where the counter is 0, do the commit (below) and go to RESP.
  - RESP: rsp_valid=1, req_ready=0. When rsp_ready=1, go to IDLE.
- Commit at the edge that enters RESP:
  - Error check: error = (addr[1:0] != 0) or (addr[31:2] >= DEPTH_WORDS). The comparison uses the full 30-bit index with no truncation or wrap.
  - Error case: no array write. rsp_err=1, rsp_rdata=0.
  - Store: for each set wstrb bit, replace that byte lane of mem[addr[31:2]]; lanes with a clear bit are untouched. wstrb=0 is legal and writes nothing. rsp_rdata=0, rsp_err=0.
  - Load: rsp_rdata = the full word of mem[addr[31:2]] at commit time. rsp_err=0.
- rsp_rdata and rsp_err are registered. They are stable for the whole RESP state and are 0 in IDLE and WAIT.
- Request inputs are sampled only in the IDLE accept cycle. Changes to them in WAIT or RESP have no effect.
- Exactly one request is outstanding at a time. A new request is never accepted in the same cycle that a response completes.
- The memory array is not reset. Its contents persist across rst_n.

## Timing
- Reset asserted (asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset asserted in WAIT: the uncommitted store is discarded and the array is unchanged.
- Reset asserted in RESP: the response is dropped; a store committed on entry to RESP remains.
- Latency: accept edge at cycle N; rsp_valid is high from cycle N+LATENCY.
- Backpressure: if rsp_ready=0, RESP holds indefinitely with outputs unchanged.
- Handshake completion: completes at the first edge in RESP with rsp_ready=1. The next cycle is IDLE with req_ready=1.
- Minimum spacing between accepts is LATENCY+1 cycles.
- An initiator holding rsp_ready=1 continuously sees rsp_valid high for exactly one cycle.

## Test plan
- Store word then load: store 0xABCDEF11 to addr 16 with wstrb=1111, then load addr 16 -> rsp_rdata=0xABCDEF11, rsp_err=0, and mem[4]=0xABCDEF11 after the store response.
- Byte strobes: mem[3]=0xFFFFFFFF; store 0x12345678 to addr 12 with wstrb=0101 -> mem[3]=0xFF34FF78; a following load of addr 12 returns 0xFF34FF78.
- Latency: sweep LATENCY=1, 2 and 5 with rsp_ready tied high -> rsp_valid rises exactly LATENCY cycles after accept, lasts 1 cycle, and req_ready returns the cycle after.
- Backpressure: hold rsp_ready=0 for 7 cycles in RESP, and change req_addr/req_wdata meanwhile -> rsp_valid and rsp_rdata are stable, no second accept occurs, and the array is unchanged.
- Errors:
  - Load from addr 0x6 -> rsp_err=1, rsp_rdata=0.
  - Store to addr 4*DEPTH_WORDS (256) -> rsp_err=1, and no word of the array changes.
- Reset mid-operation:
  - Accept a store to addr 8 with LATENCY=4, then pulse rst_n low in WAIT -> mem[2] is unchanged, and immediately req_ready=1, rsp_valid=0, rsp_err=0.
  - Repeat with the pulse in RESP -> the store is retained.
